mult_accum_ctl: RTL

//  Controller and integrate-and-dump accumulator wrapped around the 3-cycle 18x18 signed DSP multiplier.
//  - Upstream side: accepts (a,b) sample pairs on a valid/ready handshake, drives the multiplier operand/enable pins.
//  - Downstream side: consumes the 36-bit products, sums them into a wide accumulator, emits one sum per in_last-framed block.
//  - Used for FIR taps, dot products and power estimates in the SDR datapath.

---
 rtl/mult_accum_ctl_if.sv | 31 +++
 rtl/mult_accum_ctl.sv | 85 ++++++++
 2 files changed

// File: rtl/mult_accum_ctl_if.sv
// Sample, multiplier and sum signals for mult_accum_ctl. The controller uses the slave modport;
// the master modport is the environment side (upstream source, multiplier, downstream sink).
interface mult_accum_ctl_if #(
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [17:0]      in_a;
  logic signed [17:0]      in_b;
  logic                    in_last;
  logic                    mult_en;
  logic signed [17:0]      mult_a;
  logic signed [17:0]      mult_b;
  logic signed [35:0]      mult_p;
  logic                    out_valid;
  logic                    out_ready;
  logic [ACC_W-1:0]        out_data;
  logic [CNT_W-1:0]        out_count;
  logic                    out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_last, mult_p, out_ready,
    output in_ready, mult_en, mult_a, mult_b, out_valid, out_data, out_count, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_last, mult_p, out_ready,
    input  in_ready, mult_en, mult_a, mult_b, out_valid, out_data, out_count, out_ovf
  );
endinterface

// File: rtl/mult_accum_ctl.sv
// Integrate-and-dump controller around a 3-stage 18x18 DSP multiplier; a sum appears 3 enabled edges
// after the last term is accepted. A pending unaccepted sum freezes the multiplier pipe and drops in_ready.
module mult_accum_ctl #(
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  mult_accum_ctl_if.slave bus
);
  logic [2:0]       r_v;
  logic [2:0]       r_l;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf_sticky;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_data;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_ovf;

  logic             w_mult_en;
  logic             w_accept;
  logic             w_fire;
  logic [ACC_W-1:0] w_prod;
  logic [ACC_W-1:0] w_sum;
  logic             w_ovf_term;
  logic [CNT_W-1:0] w_cnt_next;

  // Pipe only advances when no sum is waiting, so a held mult_p is never added twice.
  assign w_mult_en = ~(r_out_valid & ~bus.out_ready);
  assign w_accept  = bus.in_valid & w_mult_en & ~rst;
  assign w_fire    = w_mult_en & r_v[2];

  assign w_prod     = {{(ACC_W-36){bus.mult_p[35]}}, bus.mult_p};
  assign w_sum      = r_acc + w_prod;
  assign w_ovf_term = (r_acc[ACC_W-1] == w_prod[ACC_W-1]) & (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
  assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  assign bus.mult_en   = w_mult_en;
  assign bus.in_ready  = w_mult_en & ~rst;
  assign bus.mult_a    = bus.in_a;
  assign bus.mult_b    = bus.in_b;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_count = r_out_count;
  assign bus.out_ovf   = r_out_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v          <= '0;
      r_l          <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_ovf_sticky <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_count  <= '0;
      r_out_ovf    <= 1'b0;
    end else begin
      if (w_mult_en) begin
        r_v <= {r_v[1:0], w_accept};
        r_l <= {r_l[1:0], w_accept & bus.in_last};
      end
      if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      // A dump on the same edge the previous sum is taken wins over the clear.
      if (w_fire) begin
        if (r_l[2]) begin
          r_out_data   <= w_sum;
          r_out_count  <= w_cnt_next;
          r_out_ovf    <= r_ovf_sticky | w_ovf_term;
          r_out_valid  <= 1'b1;
          r_acc        <= '0;
          r_cnt        <= '0;
          r_ovf_sticky <= 1'b0;
        end else begin
          r_acc        <= w_sum;
          r_cnt        <= w_cnt_next;
          r_ovf_sticky <= r_ovf_sticky | w_ovf_term;
        end
      end
    end
  end
endmodule
